// File: rtl/pattern_detector_moore.sv
// Moore FSM spotting the serial pattern 1-0-1-1-0 with overlap.
// Define VALID_CLEAR_EN to let a gap in valid data clear any partial match.
module pattern_detector_moore (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    input  logic valid_i,
    output logic pattern
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4,
        DET   = 3'd5
    } state_t;

    state_t state;
    state_t nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = d_i ? S1    : IDLE;
            S1:      nxt = d_i ? S1    : S10;
            S10:     nxt = d_i ? S101  : IDLE;
            S101:    nxt = d_i ? S1011 : S10;
            S1011:   nxt = d_i ? S1    : DET;
            // trailing "10" of a hit seeds the next match
            DET:     nxt = d_i ? S101  : IDLE;
            default: nxt = IDLE;
        endcase
`ifdef VALID_CLEAR_EN
        if (!valid_i) nxt = IDLE;
`else
        if (!valid_i &&
            (state inside {IDLE, S1, S10, S101, S1011, DET}))
            nxt = state;
`endif
    end

    assign pattern = (state == DET);

endmodule

// File: tb/tb_pattern_detector_moore.sv
// Randomised self-checking bench for pattern_detector_moore.
// Reference model: suffix match over the history of valid bits.
module tb_pattern_detector_moore;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic d_i = 1'b0;
    logic valid_i = 1'b0;
    logic pattern;

    pattern_detector_moore dut (
        .clk     (clk),
        .rst     (rst),
        .d_i     (d_i),
        .valid_i (valid_i),
        .pattern (pattern)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [4:0] hist = '0;
    int         nbits = 0;
    logic       exp_pat = 1'b0;
    logic       prev_pat = 1'b0;
    int         ndet = 0;
    logic       soak_bits[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic d);
        @(negedge clk);
        rst = r;
        valid_i = v;
        d_i = d;
        @(posedge clk);
        if (r) begin
            hist = '0;
            nbits = 0;
            exp_pat = 1'b0;
        end else if (v) begin
            hist = {hist[3:0], d};
            nbits++;
            exp_pat = (nbits >= 5) && (hist == 5'b10110);
        end else begin
`ifdef VALID_CLEAR_EN
            hist = '0;
            nbits = 0;
            exp_pat = 1'b0;
`endif
        end
        #1;
        chk("pattern_vs_model", int'(pattern), int'(exp_pat));
        if (pattern === 1'b1 && prev_pat !== 1'b1) ndet++;
        prev_pat = pattern;
    endtask

    task automatic feed(input logic [15:0] bits, input int len);
        for (int i = len - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i]);
    endtask

    task automatic do_reset();
        step(1'b1, 1'($urandom), 1'($urandom));
        ndet = 0;
    endtask

    initial begin
        int ref_cnt;
        logic b;

        step(1'b1, 1'($urandom), 1'($urandom));
        step(1'b1, 1'($urandom), 1'($urandom));
        chk("reset_pattern", int'(pattern), 0);
        ndet = 0;
        feed(16'b10110, 5);
        chk("basic_high", int'(pattern), 1);
        step(1'b0, 1'b1, 1'b0);
        chk("basic_one_cycle", int'(pattern), 0);
        chk("basic_count", ndet, 1);

        do_reset();
        feed(16'b10110110, 8);
        chk("overlap_count", ndet, 2);

        do_reset();
        feed(16'b101110110, 9);
        chk("near_miss_a", ndet, 1);

        do_reset();
        feed(16'b100110, 6);
        chk("near_miss_b", ndet, 0);

        do_reset();
        feed(16'b101, 3);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        feed(16'b10, 2);
`ifdef VALID_CLEAR_EN
        chk("gap_count", ndet, 0);
`else
        chk("gap_count", ndet, 1);
        step(1'b0, 1'b0, 1'b1);
        chk("gap_hold_det", int'(pattern), 1);
`endif

        do_reset();
        feed(16'b1011, 4);
        step(1'b1, 1'b1, 1'b0);
        feed(16'b0, 1);
        chk("mid_reset_none", ndet, 0);
        feed(16'b10110, 5);
        chk("mid_reset_after", ndet, 1);

        do_reset();
        soak_bits.delete();
        for (int i = 0; i < 600; i++) begin
            b = 1'($urandom);
            soak_bits.push_back(b);
            step(1'b0, 1'b1, b);
        end
        ref_cnt = 0;
        for (int i = 0; i + 4 < soak_bits.size(); i++) begin
            if (soak_bits[i] && !soak_bits[i+1] && soak_bits[i+2] &&
                soak_bits[i+3] && !soak_bits[i+4])
                ref_cnt++;
        end
        chk("soak_count", ndet, ref_cnt);

        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0)
                step(1'b1, 1'($urandom), 1'($urandom));
            else
                step(1'b0, 1'($urandom_range(0, 3) != 0),
                     1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pattern_detector_moore.md
# pattern_detector_moore

Serial bit-stream pattern detector built as a Moore finite-state machine. It samples one data bit per clock while `valid_i` is high, recognises the 5-bit sequence 1-0-1-1-0 (first-received bit first), and allows detections to overlap. It sits behind a serial data source and drives a one-state-wide detect flag to downstream counting or interrupt logic. The output depends only on the current state.

## Interface
Parameters:
- none; the pattern is fixed at 1-0-1-1-0.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  reset. One clock; reset is synchronous and active-high.
- `d_i`  input  1  serial data bit, sampled on the rising `clk` edge when `valid_i`=1.
- `valid_i`  input  1  qualifies `d_i`; 0 means no bit this cycle.
- `pattern`  output  1  high while the FSM is in state DET. Decoded from the state register only.

## Operation
- States: IDLE, S1 ("1"), S10 ("10"), S101 ("101"), S1011 ("1011"), DET ("10110" complete).
- Each state names the longest received suffix that is also a prefix of the pattern.
- Transitions on a valid bit (bit 0 / bit 1):
  - IDLE: 0→IDLE, 1→S1
  - S1: 0→S10, 1→S1
  - S10: 0→IDLE, 1→S101
  - S101: 0→S10, 1→S1011
  - S1011: 0→DET, 1→S1
  - DET: 0→IDLE, 1→S101. This is the overlap case: the trailing "10" counts as the start of the next pattern.
- `valid_i`=0: the state holds and `d_i` is ignored. This is the default; see Configuration.
- `pattern` = (state == DET). It is not an edge pulse. If `valid_i` drops while in DET, `pattern` stays high until the next valid bit.
- Undefined or unused state encodings go to IDLE on the next edge.
- `rst`=1 has priority over `valid_i` and `d_i`.

## Timing
- Reset: on a rising edge with `rst`=1, the state becomes IDLE and `pattern`=0. Before the first reset edge, outputs are undefined.
- Reset asserted mid-sequence discards all partial progress. The first valid bit after `rst` deasserts is treated as bit 1 of a new sequence.
- Latency: the final 0 of the pattern is sampled at edge N, and `pattern` is high from edge N until edge N+1.
- With continuous valid bits, `pattern` is high for exactly one cycle per detection.
- Minimum spacing between overlapping detections is 3 valid bits ("10110110" gives detections after bit 5 and bit 8).
- Both `pattern` and the state are registered: there is no combinational path from `d_i` or `valid_i` to `pattern`.

## Configuration
- Macro `VALID_CLEAR_EN`.
- Defined: a rising edge with `valid_i`=0 forces the state to IDLE, so `pattern` drops. A gap in valid data breaks any partial match.
- Not defined (default): `valid_i`=0 holds the state, so a match may span gaps in valid data.

## Test plan
- Reset: hold `rst`=1 for 2 edges with random `d_i`/`valid_i` → `pattern`=0, state IDLE. Release, then feed 1,0,1,1,0 → `pattern` high for exactly 1 cycle, following the 5th sampled bit.
- Overlap: feed the valid stream 1,0,1,1,0,1,1,0 → 2 single-cycle `pattern` assertions, after bit 5 and after bit 8.
- Near misses: feed 1,0,1,1,1,0,1,1,0 → exactly 1 detection, after bit 9. Also feed 1,0,0,1,1,0 → 0 detections.
- Valid gaps: feed 1,0,1, then 3 cycles of `valid_i`=0 with `d_i` toggling, then 1,0 → 1 detection (default build). With `VALID_CLEAR_EN` defined → 0 detections.
- Reset mid-pattern: feed 1,0,1,1, pulse `rst` for 1 edge, then feed 0 → no detection. Then feed 1,0,1,1,0 → 1 detection.
- Random soak: 600 consecutive valid random bits (seeded) → the count of `pattern` rising edges equals the number of overlapping "10110" occurrences computed by a reference model.
